// File: rtl/alu_pkg.sv
// Shared ALU package: nibble lane geometry, saturation bounds and the
// sequencer state encoding used by the nibble-serial lane units.
package alu_pkg;

  localparam int NIBBLE_W = 4;
  localparam int LANES    = 4;

  localparam logic [NIBBLE_W-1:0] SAT_MAX = 4'h7;
  localparam logic [NIBBLE_W-1:0] SAT_MIN = 4'h8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_psubsb_seq_nibble.sv
// psubsb_nibble: combinational 4-bit signed saturating subtract (a - b).
// Both nibbles are sign-extended to 5 bits so the raw difference never wraps.
module psubsb_nibble
  import alu_pkg::*;
(
  input  logic signed [NIBBLE_W-1:0] a,
  input  logic signed [NIBBLE_W-1:0] b,
  output logic        [NIBBLE_W-1:0] y,
  output logic                       sat
);

  logic signed [NIBBLE_W:0] diff;
  logic        [NIBBLE_W:0] sat_y;

  // Clamp a 5-bit signed difference into the 4-bit signed range; MSB is the saturation flag.
  function automatic logic [NIBBLE_W:0] saturate(input logic signed [NIBBLE_W:0] d);
    if (d > $signed(5'sd7))
      return {1'b1, SAT_MAX};
    else if (d < $signed(-5'sd8))
      return {1'b1, SAT_MIN};
    else
      return {1'b0, d[NIBBLE_W-1:0]};
  endfunction

  // Sign-extend, subtract, saturate.
  always_comb begin
    diff  = $signed({a[NIBBLE_W-1], a}) - $signed({b[NIBBLE_W-1], b});
    sat_y = saturate(diff);
    y     = sat_y[NIBBLE_W-1:0];
    sat   = sat_y[NIBBLE_W];
  end

endmodule

// File: rtl/alu_psubsb_seq.sv
// alu_psubsb_seq: nibble-serial saturating parallel subtractor.
// Four independent signed nibble differences are produced one lane per cycle
// through a single shared psubsb_nibble, behind a start/done handshake.
// Optional flag outputs (ovfl/zero/sign) are built only when the macro
// ALU_PSUBSB_FLAGS_EN is defined; otherwise they are tied low.
module alu_psubsb_seq
  import alu_pkg::NIBBLE_W;
  import alu_pkg::state_t;
  import alu_pkg::IDLE;
  import alu_pkg::RUN;
  import alu_pkg::DONE;
#(
  parameter int LANES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NIBBLE_W*LANES-1:0] a,
  input  logic [NIBBLE_W*LANES-1:0] b,
  output logic                      busy,
  output logic                      done,
  output logic [NIBBLE_W*LANES-1:0] result,
  output logic                      ovfl,
  output logic                      zero,
  output logic                      sign
);

  localparam int W = NIBBLE_W * LANES;

  state_t                     state;
  logic [1:0]                 idx;
  logic [W-1:0]               opa_p0;
  logic [W-1:0]               opb_p0;
  logic [W-1:0]               result_nxt;
  logic signed [NIBBLE_W-1:0] lane_a;
  logic signed [NIBBLE_W-1:0] lane_b;
  logic [NIBBLE_W-1:0]        lane_y;
  logic                       lane_sat;

  // Select the current lane of the captured operands.
  always_comb begin
    lane_a = $signed(opa_p0[idx*NIBBLE_W +: NIBBLE_W]);
    lane_b = $signed(opb_p0[idx*NIBBLE_W +: NIBBLE_W]);
  end

  psubsb_nibble u_lane (
    .a   (lane_a),
    .b   (lane_b),
    .y   (lane_y),
    .sat (lane_sat)
  );

  // Result with the current lane replaced by this cycle's saturated difference.
  always_comb begin
    result_nxt = result;
    result_nxt[idx*NIBBLE_W +: NIBBLE_W] = lane_y;
  end

  // Sequencer: capture operands in IDLE, walk lanes 0..3 in RUN, pulse DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 2'd0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa_p0 <= a;
            opb_p0 <= b;
            result <= '0;
            idx    <= 2'd0;
            state  <= RUN;
          end
        end
        RUN: begin
          result <= result_nxt;
          idx    <= idx + 2'd1;
          if (idx == 2'd3)
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

`ifdef ALU_PSUBSB_FLAGS_EN
  logic acc;

  // Accumulate lane saturation and register the flags as the last lane lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= 1'b0;
      ovfl <= 1'b0;
      zero <= 1'b0;
      sign <= 1'b0;
    end else if (state == IDLE && start) begin
      acc <= 1'b0;
    end else if (state == RUN) begin
      acc <= acc | lane_sat;
      if (idx == 2'd3) begin
        ovfl <= acc | lane_sat;
        zero <= (result_nxt == '0);
        sign <= result_nxt[W-1];
      end
    end
  end
`else
  logic unused_lane_sat;
  assign unused_lane_sat = lane_sat;
  assign ovfl = 1'b0;
  assign zero = 1'b0;
  assign sign = 1'b0;
`endif

endmodule

// File: tb/tb_alu_psubsb_seq.sv
// Self-checking bench for alu_psubsb_seq: directed operations with a queue
// scoreboard, operand/start interference during RUN, and mid-run reset.
module tb_alu_psubsb_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovfl;
  logic        zero;
  logic        sign;

  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];

  alu_psubsb_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovfl   (ovfl),
    .zero   (zero),
    .sign   (sign)
  );

  always #5 clk = ~clk;

  // Reference: {ovfl, zero, sign, result} for the given operands.
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] r;
    logic        ov;
    int          xa, yb, d;
    r  = '0;
    ov = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xa = int'(x[4*i +: 4]);
      yb = int'(y[4*i +: 4]);
      if (xa > 7) xa -= 16;
      if (yb > 7) yb -= 16;
      d = xa - yb;
      if (d > 7) begin
        r[4*i +: 4] = 4'h7;
        ov = 1'b1;
      end else if (d < -8) begin
        r[4*i +: 4] = 4'h8;
        ov = 1'b1;
      end else begin
        r[4*i +: 4] = 4'(d);
      end
    end
`ifdef ALU_PSUBSB_FLAGS_EN
    return {ov, (r == 16'h0000), r[15], r};
`else
    return {3'b000, r};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse; returns at the falling edge after the sampling edge.
  task automatic launch(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    exp_q.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    check("no_done_after_start", {31'b0, done}, 32'd0);
  endtask

  // Wait (bounded) for done, score the result, and confirm a single-cycle pulse.
  task automatic finish_op(input string tag, input int lat0);
    int lat;
    logic [18:0] e;
    lat = lat0;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_done_seen"}, {31'b0, done}, 32'd1);
    check({tag, "_latency"}, lat, 32'd4);
    check({tag, "_busy_in_done"}, {31'b0, busy}, 32'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_result"}, {16'b0, result}, {16'b0, e[15:0]});
      check({tag, "_ovfl"}, {31'b0, ovfl}, {31'b0, e[18]});
      check({tag, "_zero"}, {31'b0, zero}, {31'b0, e[17]});
      check({tag, "_sign"}, {31'b0, sign}, {31'b0, e[16]});
    end
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", {16'b0, result}, 32'h0);
    check("rst_ovfl", {31'b0, ovfl}, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_sign", {31'b0, sign}, 32'd0);

    // Reset and start together: reset wins.
    start = 1'b1;
    a = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    check("rst_start_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;

    launch(16'h7777, 16'h1111);
    finish_op("sub_6666", 0);
    check("tp_6666_result", {16'b0, result}, 32'h6666);

    launch(16'h7000, 16'h8000);
    finish_op("sat_pos", 0);
    check("tp_7000_result", {16'b0, result}, 32'h7000);

    launch(16'h8888, 16'h1111);
    finish_op("sat_neg", 0);
    check("tp_8888_result", {16'b0, result}, 32'h8888);

    launch(16'hA5C3, 16'hA5C3);
    finish_op("equal", 0);
    check("tp_equal_result", {16'b0, result}, 32'h0000);

    // Flags and result hold in IDLE.
    repeat (3) @(negedge clk);
    check("hold_result", {16'b0, result}, 32'h0000);

    // Operand changes and a start pulse during RUN are ignored.
    launch(16'h1234, 16'h4321);
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op("run_ignore", 2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_second_op_busy", {31'b0, busy}, 32'd0);
      check("no_second_op_done", {31'b0, done}, 32'd0);
    end

    // Reset mid-RUN discards the partial result and suppresses done.
    launch(16'h7777, 16'h1111);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", {16'b0, result}, 32'h0);
    check("midrst_ovfl", {31'b0, ovfl}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_no_done", {31'b0, done}, 32'd0);
    end
    launch(16'h3C5A, 16'hC3A5);
    finish_op("after_rst", 0);

    // A few random operand pairs through the scoreboard.
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      launch(ra, rb);
      finish_op("random", 0);
    end

    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
